ram_bank: RTL

- Parametrised successor to the team's basic asynchronous-read RAM: a true one-write/one-read-port synchronous memory for the mips32 data path.
- Byte-lane write enables.
- Valid/ready request handshakes on both ports.
- Configurable read latency with back-pressure.
- Selectable same-address read/write collision semantics.
- Sits between the load/store unit and backing storage.

---
 rtl/ram_bank_pkg.sv | 42 ++++
 rtl/ram_bank_rd_pipe.sv | 49 ++++
 rtl/ram_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ram_bank_pkg.sv
// Purpose: shared constants and byte-lane helpers for the ram_bank memory.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Helpers work on a fixed maximum-width word; callers zero-extend on the way
// in and truncate to their own width on the way out.
package ram_bank_pkg;

    localparam int BYTE_WIDTH     = 8;
    localparam int MIN_LATENCY    = 1;
    localparam int MAX_LATENCY    = 4;
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BYTES      = MAX_DATA_WIDTH / BYTE_WIDTH;

    typedef logic [MAX_DATA_WIDTH-1:0] word_t;
    typedef logic [MAX_BYTES-1:0]      lanes_t;

    // Number of byte lanes in a word of the given width.
    function automatic int nbytes(input int width);
        return width / BYTE_WIDTH;
    endfunction

    // Replace the bytes of old_word selected by be with the bytes of new_word.
    function automatic word_t byte_merge(input word_t old_word, input word_t new_word,
                                         input lanes_t be);
        word_t res;
        for (int i = 0; i < MAX_BYTES; i++) begin
            res[i*BYTE_WIDTH +: BYTE_WIDTH] = be[i] ? new_word[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                    : old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return res;
    endfunction

    // Even parity per byte: bit i makes byte i plus its parity bit hold an even count of ones.
    function automatic lanes_t byte_parity(input word_t w);
        lanes_t p;
        for (int i = 0; i < MAX_BYTES; i++) begin
            p[i] = ^w[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return p;
    endfunction

endpackage

// File: rtl/ram_bank_rd_pipe.sv
// Purpose: stall-able valid/data/error delay line carrying read responses.
// Latency: LATENCY cycles from capture to tail when not stalled.
// Backpressure: stall freezes every stage; tail outputs hold while stalled.
// Ports: clock/reset (sync, active-high), stall, cap_* (stage 0 load),
// tail_* (last stage = response). Bubbles travel with the data, never squeezed out.
module ram_bank_rd_pipe #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             cap_vld,
    input  logic [WIDTH-1:0] cap_dat,
    input  logic             cap_err,
    output logic             tail_vld,
    output logic [WIDTH-1:0] tail_dat,
    output logic             tail_err
);

    logic             vld_q [LATENCY];
    logic [WIDTH-1:0] dat_q [LATENCY];
    logic             err_q [LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else if (!stall) begin
            vld_q[0] <= cap_vld;
            dat_q[0] <= cap_dat;
            // Error only travels with a real request so rsp_err never flags a bubble.
            err_q[0] <= cap_vld && cap_err;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    assign tail_vld = vld_q[LATENCY-1];
    assign tail_dat = dat_q[LATENCY-1];
    assign tail_err = err_q[LATENCY-1];

endmodule

// File: rtl/ram_bank.sv
// Purpose: 1W/1R synchronous RAM with byte enables and valid/ready ports.
// Latency: READ_LATENCY cycles from read accept to rsp_valid (no stall).
// Backpressure: rsp_valid && !rsp_ready freezes the read pipe and drops rd_ready; writes always accepted.
// Ports: clock, reset (sync, active-high); wr_valid/wr_ready/wr_addr/wr_data/wr_be;
// rd_valid/rd_ready/rd_addr; rsp_valid/rsp_ready/rsp_data/rsp_err.
// Build option: define RAM_BANK_PARITY_EN to store and check per-byte even parity.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_be,
    input  logic                           rd_valid,
    output logic                           rd_ready,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err
);

    localparam int NB    = nbytes(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (READ_LATENCY < MIN_LATENCY || READ_LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("ram_bank: READ_LATENCY must lie in 1..4");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("ram_bank: DATA_WIDTH must be a multiple of 8 and at most 256");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  stall;
    logic                  rd_fire;
    logic                  hit;
    logic [DATA_WIDTH-1:0] old_dat;
    logic [DATA_WIDTH-1:0] cap_dat;
    logic                  cap_err;

    assign wr_ready = 1'b1;
    assign stall    = rsp_valid && !rsp_ready;
    assign rd_ready = !stall;
    assign rd_fire  = rd_valid && rd_ready;
    // Same-cycle write to the word being read; only matters when BYPASS is set.
    assign hit      = wr_valid && (wr_addr == rd_addr);

    // Writes during reset are dropped; contents are never cleared.
    always_ff @(posedge clock) begin
        if (!reset && wr_valid) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // The array is sampled at the accept edge: the old word, optionally
    // overlaid with the bytes being written in the same cycle.
    assign old_dat = mem[rd_addr];

    always_comb begin
        cap_dat = old_dat;
        if (BYPASS != 0 && hit) begin
            cap_dat = DATA_WIDTH'(byte_merge(word_t'(old_dat), word_t'(wr_data), lanes_t'(wr_be)));
        end
    end

`ifdef RAM_BANK_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par;
    logic [NB-1:0] old_par;
    logic [NB-1:0] cap_par;
    logic [NB-1:0] chk_par;

    assign wr_par = NB'(byte_parity(word_t'(wr_data)));

    always_ff @(posedge clock) begin
        if (!reset && wr_valid) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    par_mem[wr_addr][i] <= wr_par[i];
                end
            end
        end
    end

    assign old_par = par_mem[rd_addr];

    // Bypassed bytes take their parity from the write data, matching what
    // will be stored; the captured word is then rechecked lane by lane.
    always_comb begin
        cap_par = old_par;
        if (BYPASS != 0 && hit) begin
            cap_par = (old_par & ~wr_be) | (wr_par & wr_be);
        end
        chk_par = NB'(byte_parity(word_t'(cap_dat)));
        cap_err = |(chk_par ^ cap_par);
    end
`else
    assign cap_err = 1'b0;
`endif

    ram_bank_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (DATA_WIDTH)
    ) u_rd_pipe (
        .clock    (clock),
        .reset    (reset),
        .stall    (stall),
        .cap_vld  (rd_fire),
        .cap_dat  (cap_dat),
        .cap_err  (cap_err),
        .tail_vld (rsp_valid),
        .tail_dat (rsp_data),
        .tail_err (rsp_err)
    );

endmodule
